// File: rtl/crypto_pipe_if.sv
// Handshake bundle for crypto_pipe: input beat (data, key, mode) and result stream.
// master drives beats and accepts results; slave is the pipeline.
interface crypto_pipe_if #(
    parameter int DW = 16,
    parameter int KW = 5
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [KW-1:0] key_bits;
    logic          mode;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;

    modport master (
        output in_valid, in_data, key_bits, mode, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, key_bits, mode, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/crypto_pipe.sv
// ROUNDS-stage rotate/xor/add cipher pipeline; every beat carries its own key and mode.
// The whole pipe shifts together whenever the last stage is empty or being drained.
module crypto_pipe #(
    parameter int DW     = 16,
    parameter int KW     = 5,
    parameter int ROUNDS = 3
) (
    input  logic          clk,
    input  logic          rst,
    crypto_pipe_if.slave  bus,
    output logic          busy,
    output logic [15:0]   done_count
);

    localparam logic [DW-1:0] DW_V = DW'(DW);

    logic              advance_s;
    logic              in_ready_s;
    logic [ROUNDS-1:0] valid_vec_s;
    logic [15:0]       done_count_r;

    function automatic logic [DW-1:0] rotl(input logic [DW-1:0] x, input logic [6:0] s);
        logic [2*DW-1:0] t;
        t = {x, x} << s;
        return t[2*DW-1:DW];
    endfunction

    function automatic logic [DW-1:0] rotr(input logic [DW-1:0] x, input logic [6:0] s);
        logic [2*DW-1:0] t;
        t = {x, x} >> s;
        return t[DW-1:0];
    endfunction

    // One cipher round; decrypt is the exact inverse of encrypt for the same round index.
    function automatic logic [DW-1:0] cipher_round(input logic [DW-1:0] x,
                                                   input logic [KW-1:0] key,
                                                   input logic          dec,
                                                   input logic [4:0]    rnd);
        logic [DW-1:0] k;
        logic [DW-1:0] rk;
        logic [DW-1:0] rem;
        logic [6:0]    s;
        k          = '0;
        k[KW-1:0]  = key;
        rem        = k % DW_V;
        s          = rem[6:0];
        rk         = k ^ {{(DW-5){1'b0}}, rnd};
        if (dec) begin
            return rotr(x - rk, s) ^ rk;
        end else begin
            return rotl(x ^ rk, s) + rk;
        end
    endfunction

    for (genvar i = 0; i < ROUNDS; i++) begin : g_stage
        localparam logic [4:0] ENC_RND = 5'(i);
        localparam logic [4:0] DEC_RND = 5'(ROUNDS - 1 - i);

        logic          valid_r;
        logic          mode_r;
        logic [DW-1:0] data_r;
        logic [KW-1:0] key_r;
        logic          src_valid_s;
        logic          src_mode_s;
        logic [DW-1:0] src_data_s;
        logic [KW-1:0] src_key_s;

        if (i == 0) begin : g_head
            assign src_valid_s = bus.in_valid & in_ready_s;
            assign src_mode_s  = bus.mode;
            assign src_data_s  = bus.in_data;
            assign src_key_s   = bus.key_bits;
        end else begin : g_body
            assign src_valid_s = g_stage[i-1].valid_r;
            assign src_mode_s  = g_stage[i-1].mode_r;
            assign src_data_s  = g_stage[i-1].data_r;
            assign src_key_s   = g_stage[i-1].key_r;
        end

        // Stage register: applies this stage's round while the pipe advances, holds otherwise.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_r <= 1'b0;
                mode_r  <= 1'b0;
                data_r  <= '0;
                key_r   <= '0;
            end else if (advance_s) begin
                valid_r <= src_valid_s;
                mode_r  <= src_mode_s;
                key_r   <= src_key_s;
                data_r  <= cipher_round(src_data_s, src_key_s, src_mode_s,
                                        src_mode_s ? DEC_RND : ENC_RND);
            end
        end

        assign valid_vec_s[i] = valid_r;
    end

    assign advance_s     = ~g_stage[ROUNDS-1].valid_r | bus.out_ready;
    assign in_ready_s    = advance_s & ~rst;
    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = g_stage[ROUNDS-1].valid_r;
    assign bus.out_data  = g_stage[ROUNDS-1].data_r;
    assign busy          = |valid_vec_s;
    assign done_count    = done_count_r;

    // Completed output handshakes, wrapping naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_count_r <= 16'h0000;
        end else if (bus.out_valid & bus.out_ready) begin
            done_count_r <= done_count_r + 16'h0001;
        end
    end

endmodule

// File: tb/tb_crypto_pipe.sv
// Randomized bench for crypto_pipe: a queue scoreboard fed by a plain-arithmetic cipher model,
// plus directed vectors, a stall window, reset flush, round trips and done_count wrap.
module tb_crypto_pipe;
    localparam int R = 3;

    logic        clk;
    logic        rst;
    logic        busy;
    logic [15:0] done_count;
    logic        w_busy;
    logic [15:0] w_done_count;

    crypto_pipe_if #(.DW(16), .KW(5)) bus ();
    crypto_pipe_if #(.DW(32), .KW(6)) w ();

    crypto_pipe #(.DW(16), .KW(5), .ROUNDS(R)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave), .busy(busy), .done_count(done_count));

    crypto_pipe #(.DW(32), .KW(6), .ROUNDS(16)) dut_w (
        .clk(clk), .rst(rst), .bus(w.slave), .busy(w_busy), .done_count(w_done_count));

    int total = 0;
    int bad   = 0;
    int model_done = 0;
    bit capture = 0;
    logic [63:0] exp_q[$];
    logic [15:0] ct_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned rot(input longint unsigned x, input int s, input int dw,
                                            input longint unsigned mask, input bit left);
        if (s == 0) return x;
        if (left) return ((x << s) | (x >> (dw - s))) & mask;
        return ((x >> s) | (x << (dw - s))) & mask;
    endfunction

    // Reference cipher straight from the round definitions.
    function automatic longint unsigned model(input longint unsigned x, input longint unsigned key,
                                              input bit dec, input int dw, input int rounds);
        longint unsigned mask, k, rk;
        int s, r;
        mask = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << dw) - 64'd1);
        k = key;
        s = int'(k % longint'(dw));
        x = x & mask;
        for (int i = 0; i < rounds; i++) begin
            r  = dec ? (rounds - 1 - i) : i;
            rk = k ^ longint'(r);
            if (!dec) x = (rot(x ^ rk, s, dw, mask, 1'b1) + rk) & mask;
            else      x = rot((x - rk) & mask, s, dw, mask, 1'b0) ^ rk;
        end
        return x;
    endfunction

    // Scoreboard: every output handshake must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            model_done = 0;
        end else if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) check("unexpected_out", 64'd1, 64'd0);
            else check("out_data", bus.out_data, exp_q.pop_front());
            if (capture) ct_q.push_back(bus.out_data);
            model_done++;
        end
    end

    task automatic send(input logic [15:0] d, input logic [4:0] k, input logic m, input logic [15:0] e);
        bit acc;
        int n;
        bus.in_valid = 1'b1; bus.in_data = d; bus.key_bits = k; bus.mode = m;
        acc = 1'b0; n = 0;
        while (!acc && n < 200) begin
            @(negedge clk); acc = bus.in_ready;
            @(posedge clk); #1; n++;
        end
        bus.in_valid = 1'b0;
        if (acc) exp_q.push_back(64'(e));
        else check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_rand();
        logic [15:0] d;
        logic [4:0]  k;
        logic        m;
        d = 16'($urandom); k = 5'($urandom); m = 1'($urandom);
        send(d, k, m, 16'(model(64'(d), 64'(k), m, 16, R)));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 500) begin @(posedge clk); n++; end
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Single beat with latency check and a spec-given expected value.
    task automatic run_one(input logic [15:0] d, input logic [4:0] k, input logic m, input logic [15:0] e);
        send(d, k, m, e);
        for (int c = 0; c < R - 1; c++) begin
            @(negedge clk); check("early_valid", bus.out_valid, 64'd0);
            @(posedge clk);
        end
        @(negedge clk);
        check("lat_valid", bus.out_valid, 64'd1);
        check("lat_data", bus.out_data, e);
        @(posedge clk); #1;
    endtask

    task automatic w_xfer(input logic [31:0] d, input logic [5:0] k, input logic m, output logic [31:0] r);
        bit acc;
        int n;
        w.in_valid = 1'b1; w.in_data = d; w.key_bits = k; w.mode = m;
        acc = 1'b0; n = 0;
        while (!acc && n < 100) begin
            @(negedge clk); acc = w.in_ready;
            @(posedge clk); #1; n++;
        end
        w.in_valid = 1'b0;
        r = '0; n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (w.out_valid) begin r = w.out_data; break; end
            n++;
        end
        if (!acc || n >= 100) check("w_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [15:0] held, p;
        logic [4:0]  k;
        logic [31:0] wp, wc, wr;
        logic [5:0]  wk;
        logic [15:0] pq[$];
        logic [4:0]  kq[$];
        bit          stream_done;
        int          need;

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.key_bits = '0; bus.mode = 1'b0; bus.out_ready = 1'b1;
        w.in_valid = 1'b0; w.in_data = '0; w.key_bits = '0; w.mode = 1'b0; w.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 64'd0);
        check("rst_out_data", bus.out_data, 64'd0);
        check("rst_busy", busy, 64'd0);
        check("rst_in_ready", bus.in_ready, 64'd0);
        check("rst_done_count", done_count, 64'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", bus.in_ready, 64'd1);
        @(posedge clk); #1;

        run_one(16'h0001, 5'b00011, 1'b0, 16'h0459);
        check("done_after_first", done_count, 64'd1);
        run_one(16'h0459, 5'b00011, 1'b1, 16'h0001);
        run_one(16'h0000, 5'b00000, 1'b0, 16'h0002);

        // Eight back-to-back beats with a five-cycle output stall in the middle.
        fork
            begin
                for (int b = 0; b < 8; b++) send_rand();
            end
            begin
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    if (c == 0) held = bus.out_data;
                    check("stall_valid", bus.out_valid, 64'd1);
                    check("stall_in_ready", bus.in_ready, 64'd0);
                    check("stall_hold", bus.out_data, held);
                    @(posedge clk);
                end
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();
        check("done_after_stream", done_count, 64'd11);

        // Reset with two beats in flight.
        send_rand();
        send_rand();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("flush_out_valid", bus.out_valid, 64'd0);
        check("flush_busy", busy, 64'd0);
        @(posedge clk); #1; rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); check("flush_ghost", bus.out_valid, 64'd0);
        end
        check("flush_done_count", done_count, 64'd0);
        @(posedge clk); #1;
        p = 16'($urandom); k = 5'($urandom);
        run_one(p, k, 1'b0, 16'(model(64'(p), 64'(k), 1'b0, 16, R)));

        // Mixed modes and keys under random backpressure.
        stream_done = 1'b0;
        fork
            begin
                for (int b = 0; b < 200; b++) send_rand();
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(posedge clk); #1 bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("done_mixed", done_count, 64'(model_done));

        // Round trip: decrypt the observed ciphertexts and expect the plaintexts back.
        capture = 1'b1;
        for (int b = 0; b < 40; b++) begin
            p = 16'($urandom); k = 5'($urandom);
            pq.push_back(p); kq.push_back(k);
            send(p, k, 1'b0, 16'(model(64'(p), 64'(k), 1'b0, 16, R)));
        end
        drain();
        capture = 1'b0;
        check("ct_count", 64'(ct_q.size()), 64'd40);
        for (int b = 0; b < 40 && b < ct_q.size(); b++) send(ct_q[b], kq[b], 1'b1, pq[b]);
        drain();

        // Wide, deep instance: model check plus round trip.
        for (int b = 0; b < 20; b++) begin
            wp = $urandom; wk = 6'($urandom);
            w_xfer(wp, wk, 1'b0, wc);
            check("w_enc", wc, model(64'(wp), 64'(wk), 1'b0, 32, 16));
            w_xfer(wc, wk, 1'b1, wr);
            check("w_roundtrip", wr, wp);
        end

        // Stream to exactly 65536 handshakes since reset, then one more.
        need = 65536 - model_done;
        for (int b = 0; b < need; b++) send_rand();
        drain();
        check("wrap_zero", done_count, 64'd0);
        send_rand();
        drain();
        check("wrap_one", done_count, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/crypto_pipe.md
CRYPTO_PIPE -- requirements
Module: crypto_pipe

Interface
REQ-001 Parameter DW, default 16, data width in bits; legal values 8..64.
REQ-002 Parameter KW, default 5, key width in bits; legal values 1..DW.
REQ-003 Parameter ROUNDS, default 3, number of cipher rounds and pipeline stages; legal values 1..16.
REQ-004 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 Port rst, input, 1, synchronous active-high reset.
REQ-006 Port in_valid, input, 1, input beat offered.
REQ-007 Port in_ready, output, 1, block accepts input beat this cycle.
REQ-008 Port in_data, input, DW, plaintext or ciphertext.
REQ-009 Port key_bits, input, KW, per-beat key, sampled with in_data.
REQ-010 Port mode, input, 1, per-beat mode: 0 = encrypt, 1 = decrypt; sampled with in_data.
REQ-011 Port out_valid, output, 1, result beat available.
REQ-012 Port out_ready, input, 1, downstream accepts result.
REQ-013 Port out_data, output, DW, result.
REQ-014 Port busy, output, 1, OR of all stage valid bits.
REQ-015 Port done_count, output, 16, count of completed output handshakes.

Function
REQ-016 The block SHALL be a ROUNDS-stage pipeline; each stage SHALL hold valid, data, key and mode registers.
REQ-017 Definitions: K = zero-extended key_bits to DW bits; s = K mod DW; rk_r = K XOR r, where r is the round index zero-extended to DW bits.
REQ-018 Encrypt round r SHALL compute x' = rotl(x XOR rk_r, s) + rk_r mod 2^DW.
REQ-019 Encrypt SHALL apply rounds r = 0..ROUNDS-1 in order, with stage i performing round i.
REQ-020 Decrypt round r SHALL compute x' = rotr((x - rk_r) mod 2^DW, s) XOR rk_r.
REQ-021 Decrypt SHALL apply rounds r = ROUNDS-1..0, with stage i performing round ROUNDS-1-i.
REQ-022 Decrypt(Encrypt(p, key)) SHALL equal p for every p and key.
REQ-023 advance = NOT last_stage_valid OR out_ready; the whole pipeline SHALL shift one stage only when advance = 1.
REQ-024 in_ready SHALL equal advance AND NOT rst.
REQ-025 An input beat is accepted when in_valid AND in_ready; stage 0 valid SHALL load in_valid AND in_ready on advance.
REQ-026 A bubble (valid 0) SHALL propagate when no input beat is accepted; results SHALL stay in order.
REQ-027 Latency: a beat accepted at edge N SHALL appear on out_valid/out_data after edge N+ROUNDS-1, provided no stall occurs.
REQ-028 Throughput SHALL be one beat per cycle while out_ready = 1.
REQ-029 With out_valid = 1 and out_ready = 0, all stages, out_data and out_valid SHALL hold.
REQ-030 Simultaneous output handshake and input accept in the same cycle SHALL both complete.
REQ-031 out_data and out_valid SHALL be driven directly from the last stage's registers (registered outputs).
REQ-032 Mixed encrypt/decrypt beats and mixed keys SHALL each use only their own sampled key and mode.
REQ-033 done_count SHALL increment on each out_valid AND out_ready and SHALL wrap from 0xFFFF to 0x0000.

Reset
REQ-034 While rst = 1, all stage valid bits SHALL clear, all data/key/mode registers SHALL clear to 0, and done_count SHALL clear to 0.
REQ-035 While rst = 1, out_valid = 0, out_data = 0, busy = 0 and in_ready = 0.
REQ-036 Reset mid-operation SHALL discard all in-flight beats; no output for them SHALL ever appear.
REQ-037 In the first cycle after rst deasserts, in_ready SHALL be 1.

Verification
REQ-038 Defaults, encrypt, key 5'b00011, in_data 0x0001 -> out_data 0x0459 three cycles later; done_count = 1.
REQ-039 Defaults, decrypt, key 5'b00011, in_data 0x0459 -> out_data 0x0001.
REQ-040 Defaults, encrypt, key 0, in_data 0x0000 -> out_data 0x0002.
REQ-041 Stream 8 beats back-to-back, out_ready = 0 for 5 cycles mid-stream -> in_ready drops, no beat lost or duplicated, outputs in order, done_count = 8.
REQ-042 Assert rst with 2 beats in flight -> out_valid = 0 and busy = 0 after that edge; the discarded beats never appear; a new beat issued after reset completes correctly.
REQ-043 Random p, key and mode over DW in {8, 16, 32} and ROUNDS in {1, 3, 16} -> round-trip identity holds; done_count wraps correctly after 65536 beats.
